regfile_mp: RTL

Parametrised multi-port general-purpose register file with an integrated busy scoreboard for the dual-issue core. It serves NUM_RD combinational read ports with same-cycle write-through bypass and NUM_WR write ports with fixed priority. It also tracks which architectural registers have an in-flight producer. It sits between decode/issue (reads operands, marks destinations busy) and writeback (writes results, clears busy).

---
 rtl/regfile_mp.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port GPR file with write-through bypass and a busy
// scoreboard tracking registers that have an in-flight producer.

// One read port: enable/zero-register gating, bypass from this cycle's
// writes (highest write port wins), and the forwarded-means-not-busy rule.
module regfile_mp_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_WR = 2
) (
    input  logic                           en_i,
    input  logic [ADDR_W-1:0]              addr_i,
    input  logic [NUM_WR-1:0]              wr_en_i,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_i,
    input  logic [DATA_W-1:0]              stored_i,
    input  logic                           busy_i,
    output logic [DATA_W-1:0]              data_o,
    output logic                           busy_o
);
    logic              hit;
    logic [DATA_W-1:0] byp;
    logic              live;

    // Bypass search; later ports overwrite earlier ones so the youngest wins.
    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j] == addr_i)) begin
                hit = 1'b1;
                byp = wr_data_i[j];
            end
        end
    end

    assign live = en_i && (addr_i != '0);

    // Disabled ports and r0 drive zero; a forwarded result is never busy.
    always_comb begin
        data_o = '0;
        if (live) data_o = hit ? byp : stored_i;
        busy_o = live && busy_i && !hit;
    end
endmodule

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_RD-1:0]          rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
    input  logic [NUM_WR-1:0]          iss_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   iss_addr_i,
    input  logic                       flush_i,
    output logic [ADDR_W:0]            busy_cnt_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_v;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_v;
    logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr_v;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data_v;
    logic [NUM_WR-1:0][ADDR_W-1:0] iss_addr_v;
    logic [NUM_WR-1:0]             wr_live;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    assign rd_addr_v  = rd_addr_i;
    assign wr_addr_v  = wr_addr_i;
    assign wr_data_v  = wr_data_i;
    assign iss_addr_v = iss_addr_i;
    assign rd_data_o  = rd_data_v;
    assign busy_cnt_o = cnt_q;

    // Writes held in reset must not leak to readers through the bypass.
    assign wr_live = wr_en_i & {NUM_WR{~rst_i}};

    // Storage update; ascending port order lets the highest port win a collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && (wr_addr_v[j] != '0)) mem_q[wr_addr_v[j]] <= wr_data_v[j];
            end
        end
    end

    // Next busy state: clear on writeback, then set on issue (set beats clear),
    // r0 forced low, flush overrides everything.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j]) busy_d[wr_addr_v[j]] = 1'b0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (iss_en_i[j]) busy_d[iss_addr_v[j]] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (flush_i) busy_d = '0;
    end

    // Population count of the next busy state so the counter tracks the bits.
    always_comb begin
        cnt_d = '0;
        for (int e = 0; e < DEPTH; e++) cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[e]};
    end

    // Scoreboard and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_mp_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rd (
            .en_i      (rd_en_i[i]),
            .addr_i    (rd_addr_v[i]),
            .wr_en_i   (wr_live),
            .wr_addr_i (wr_addr_v),
            .wr_data_i (wr_data_v),
            .stored_i  (mem_q[rd_addr_v[i]]),
            .busy_i    (busy_q[rd_addr_v[i]]),
            .data_o    (rd_data_v[i]),
            .busy_o    (rd_busy_o[i])
        );
    end
endmodule
